// File: rtl/decoder_pkg.sv
// Shared decoder definitions: relative-branch sequencer states, instruction
// kind encodings and condition-flag indices.
package decoder_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEC   = 3'd1,
        FETCH = 3'd2,
        ADD   = 3'd3,
        FIN   = 3'd4
    } rel_state_t;

    localparam logic [1:0] KIND_JR   = 2'd0;
    localparam logic [1:0] KIND_JRCC = 2'd1;
    localparam logic [1:0] KIND_DJNZ = 2'd2;
    localparam logic [1:0] KIND_RSVD = 2'd3;

    localparam int CC_Z = 0;
    localparam int CC_C = 1;

endpackage

// File: rtl/decoder_rel_branch_seq_if.sv
// Displacement-byte ready/valid channel into the relative-branch sequencer.
interface decoder_rel_branch_seq_if #(
    parameter int OFS_W = 8
);
    logic             op_valid;
    logic [OFS_W-1:0] op_data;
    logic             op_ready;

    modport master (output op_valid, output op_data, input  op_ready);
    modport slave  (input  op_valid, input  op_data, output op_ready);
endinterface

// File: rtl/decoder_rel_branch_cond.sv
// Combinational branch-condition evaluator for JR / JR cc / DJNZ.
module decoder_rel_branch_cond
    import decoder_pkg::*;
#(
    parameter int NUM_CC = 4
) (
    input  logic [1:0]                kind,
    input  logic [$clog2(NUM_CC)-1:0] cc_sel,
    input  logic                      cc_inv,
    input  logic [NUM_CC-1:0]         flags,
    input  logic                      nz,
    output logic                      take
);
    localparam int SEL_N = 1 << $clog2(NUM_CC);

    // Selector codes beyond NUM_CC land on padding that mirrors flag 0.
    logic [SEL_N-1:0] flags_pad;
    logic             flag;

    always_comb begin
        flags_pad               = {SEL_N{flags[CC_Z]}};
        flags_pad[NUM_CC-1:0]   = flags;
        flag                    = flags_pad[cc_sel];
        case (kind)
            KIND_JR:   take = 1'b1;
            KIND_JRCC: take = flag ^ cc_inv;
            KIND_DJNZ: take = nz;
            default:   take = 1'b0;
        endcase
    end

endmodule

// File: rtl/decoder_rel_branch_seq.sv
// JR e / JR cc,e / DJNZ e step machine for the instruction decoder.
// DJNZ support is built only when DECODER_REL_BRANCH_DJNZ_EN is defined.
module decoder_rel_branch_seq
    import decoder_pkg::*;
#(
    parameter int PC_W   = 16,
    parameter int OFS_W  = 8,
    parameter int CNT_W  = 8,
    parameter int NUM_CC = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      start,
    input  logic [1:0]                kind,
    input  logic [$clog2(NUM_CC)-1:0] cc_sel,
    input  logic                      cc_inv,
    input  logic [NUM_CC-1:0]         flags,
    input  logic [PC_W-1:0]           pc_base,
    decoder_rel_branch_seq_if.slave   op,
    input  logic [CNT_W-1:0]          cnt_in,
    output logic [CNT_W-1:0]          cnt_out,
    output logic                      cnt_we,
    output logic [PC_W-1:0]           pc_out,
    output logic                      pc_we,
    output logic                      busy,
    output logic                      done
);
    localparam int SEL_W = $clog2(NUM_CC);

    rel_state_t       state, state_nxt;
    logic [1:0]       kind_eff;
    logic [1:0]       kind_q;
    logic [SEL_W-1:0] cc_sel_q;
    logic             cc_inv_q;
    logic [PC_W-1:0]  pc_base_q;
    logic [OFS_W-1:0] ofs;
    logic [PC_W-1:0]  target;
    logic             nz;
    logic             take;
    logic             go;
    logic             accept;

    always_comb begin
`ifdef DECODER_REL_BRANCH_DJNZ_EN
        kind_eff = kind;
`else
        kind_eff = (kind == KIND_DJNZ) ? KIND_RSVD : kind;
`endif
    end

    assign go     = (state == IDLE) && start;
    assign accept = (state == FETCH) && op.op_valid;
    assign ofs    = op.op_data;
    assign target = pc_base_q + PC_W'($signed(ofs));

    decoder_rel_branch_cond #(.NUM_CC(NUM_CC)) u_cond (
        .kind   (kind_q),
        .cc_sel (cc_sel_q),
        .cc_inv (cc_inv_q),
        .flags  (flags),
        .nz     (nz),
        .take   (take)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (kind_eff == KIND_DJNZ) ? DEC : FETCH;
            DEC:     state_nxt = FETCH;
            FETCH:   if (op.op_valid) state_nxt = take ? ADD : FIN;
            ADD:     state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign op.op_ready = (state == FETCH);
    assign busy        = (state != IDLE);
    assign pc_we       = (state == ADD);
    assign done        = (state == FIN);

    // The target is registered on the accept edge so it is already on pc_out
    // for the single ADD cycle where pc_we is high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            kind_q    <= KIND_JR;
            cc_sel_q  <= '0;
            cc_inv_q  <= 1'b0;
            pc_base_q <= '0;
            pc_out    <= '0;
        end else begin
            if (go) begin
                kind_q    <= kind_eff;
                cc_sel_q  <= cc_sel;
                cc_inv_q  <= cc_inv;
                pc_base_q <= pc_base;
            end
            if (accept && take) pc_out <= target;
        end
    end

`ifdef DECODER_REL_BRANCH_DJNZ_EN
    logic [CNT_W-1:0] cnt_dec;
    logic             nz_q;

    assign cnt_dec = cnt_in - CNT_W'(1);
    assign cnt_we  = (state == DEC);
    assign nz      = nz_q;

    // Decrement is captured on the edge into DEC so cnt_out/cnt_we are
    // registered; the loop register must be stable across the start cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_out <= '0;
            nz_q    <= 1'b0;
        end else if (go && kind_eff == KIND_DJNZ) begin
            cnt_out <= cnt_dec;
            nz_q    <= (cnt_dec != '0);
        end
    end
`else
    logic unused_cnt;

    assign unused_cnt = ^cnt_in;
    assign cnt_out    = '0;
    assign cnt_we     = 1'b0;
    assign nz         = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_rel_branch_seq.sv
// Scoreboard bench for decoder_rel_branch_seq: random JR/JRcc/DJNZ stream
// against a timing/arithmetic model, plus a reset-during-ADD check on a wide build.
`timescale 1ns/1ps
module tb_decoder_rel_branch_seq;
    import decoder_pkg::*;

    localparam int PC_W = 16, OFS_W = 8, CNT_W = 8, NUM_CC = 4;
`ifdef DECODER_REL_BRANCH_DJNZ_EN
    localparam bit DJ_EN = 1'b1;
`else
    localparam bit DJ_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic             start, cc_inv, cnt_we, pc_we, busy, done;
    logic [1:0]       kind, cc_sel;
    logic [3:0]       flags;
    logic [PC_W-1:0]  pc_base, pc_out;
    logic [CNT_W-1:0] cnt_in, cnt_out;

    decoder_rel_branch_seq_if #(.OFS_W(OFS_W)) op_if ();

    decoder_rel_branch_seq #(.PC_W(PC_W), .OFS_W(OFS_W), .CNT_W(CNT_W), .NUM_CC(NUM_CC)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .kind(kind), .cc_sel(cc_sel),
        .cc_inv(cc_inv), .flags(flags), .pc_base(pc_base), .op(op_if),
        .cnt_in(cnt_in), .cnt_out(cnt_out), .cnt_we(cnt_we), .pc_out(pc_out),
        .pc_we(pc_we), .busy(busy), .done(done)
    );

    logic        w_rst, w_start, w_cc_inv, w_cnt_we, w_pc_we, w_busy, w_done;
    logic [1:0]  w_kind, w_cc_sel;
    logic [3:0]  w_flags;
    logic [23:0] w_pc_base, w_pc_out;
    logic [7:0]  w_cnt_in, w_cnt_out;

    decoder_rel_branch_seq_if #(.OFS_W(16)) w_op ();

    decoder_rel_branch_seq #(.PC_W(24), .OFS_W(16), .CNT_W(8), .NUM_CC(4)) u_wide (
        .CLK(CLK), .RESET(w_rst), .start(w_start), .kind(w_kind), .cc_sel(w_cc_sel),
        .cc_inv(w_cc_inv), .flags(w_flags), .pc_base(w_pc_base), .op(w_op),
        .cnt_in(w_cnt_in), .cnt_out(w_cnt_out), .cnt_we(w_cnt_we), .pc_out(w_pc_out),
        .pc_we(w_pc_we), .busy(w_busy), .done(w_done)
    );

    int total = 0, bad = 0;
    int q_pc_cyc[$], q_pc_val[$], q_cnt_cyc[$], q_cnt_val[$], q_done[$], q_acc[$];

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: sample mid-cycle, after the driver's negedge updates.
    always begin
        @(negedge CLK);
        #2;
        if (!RESET) begin
            if (pc_we) begin
                if (q_pc_cyc.size() == 0) check("spurious_pc_we", 1, 0);
                else begin
                    check("pc_we_cycle", cyc, q_pc_cyc.pop_front());
                    check("pc_out", pc_out, q_pc_val.pop_front());
                end
            end
            if (cnt_we) begin
                if (q_cnt_cyc.size() == 0) check("spurious_cnt_we", 1, 0);
                else begin
                    check("cnt_we_cycle", cyc, q_cnt_cyc.pop_front());
                    check("cnt_out", cnt_out, q_cnt_val.pop_front());
                end
            end
            if (done) begin
                if (q_done.size() == 0) check("spurious_done", 1, 0);
                else check("done_cycle", cyc, q_done.pop_front());
            end
            if (op_if.op_ready && op_if.op_valid) begin
                if (q_acc.size() == 0) check("spurious_accept", 1, 0);
                else check("accept_cycle", cyc, q_acc.pop_front());
            end
        end
    end

    // Issue one instruction from an IDLE negedge; fl < 0 means random flags each cycle.
    task automatic run_instr(input int k, input int cs, input int ci, input int pb,
                             input int od, input int cnt, input int ns, input int fl);
        int s, acc, dcyc, ke, take, off, n;
        bit f, nz;
        ke = (k == 2 && !DJ_EN) ? 3 : k;
        start = 1'b1; kind = k[1:0]; cc_sel = cs[1:0]; cc_inv = ci[0];
        pc_base = pb[15:0]; op_if.op_data = od[7:0]; cnt_in = cnt[7:0];
        op_if.op_valid = (ns == 0);
        flags = (fl >= 0) ? fl[3:0] : 4'($urandom);
        s    = cyc;
        acc  = s + 1 + ((ke == 2) ? 1 : 0) + ns;
        dcyc = -1;
        nz   = ((cnt + 255) % 256) != 0;
        if (ke == 2) begin
            q_cnt_cyc.push_back(s + 1);
            q_cnt_val.push_back((cnt + 255) % 256);
        end
        q_acc.push_back(acc);
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if (n > 64) begin
                total++; bad++;
                $display("FAIL instr_timeout: got no done after %0d cycles", n);
                break;
            end
            start   = 1'($urandom_range(0, 1));
            kind    = 2'($urandom);
            cc_sel  = 2'($urandom);
            cc_inv  = 1'($urandom);
            pc_base = 16'($urandom);
            if (cyc > s + 1) cnt_in = 8'($urandom);
            if (cyc > acc) op_if.op_data = 8'($urandom);
            flags = (fl >= 0) ? fl[3:0] : 4'($urandom);
            op_if.op_valid = (cyc < acc) ? 1'b0 : (cyc == acc) ? 1'b1 : 1'($urandom);
            if (cyc == acc) begin
                f = (cs < NUM_CC) ? flags[cs] : flags[CC_Z];
                case (ke)
                    0:       take = 1;
                    1:       take = int'(f ^ ci[0]);
                    2:       take = int'(nz);
                    default: take = 0;
                endcase
                if (take != 0) begin
                    off = (od >= 128) ? od - 256 : od;
                    q_pc_cyc.push_back(acc + 1);
                    q_pc_val.push_back((pb + off + 65536) % 65536);
                end
                dcyc = acc + 1 + take;
                q_done.push_back(dcyc);
            end
            if (dcyc >= 0 && cyc == dcyc + 1) break;
        end
        start = 1'b0;
        op_if.op_valid = 1'b0;
    endtask

    initial begin
        int n;
        #100_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        start = 0; kind = 0; cc_sel = 0; cc_inv = 0; flags = 0; pc_base = 0; cnt_in = 0;
        op_if.op_valid = 0; op_if.op_data = 0;
        w_rst = 1; w_start = 0; w_kind = 0; w_cc_sel = 0; w_cc_inv = 0; w_flags = 0;
        w_pc_base = 0; w_cnt_in = 0; w_op.op_valid = 0; w_op.op_data = 0;
        repeat (3) @(negedge CLK);
        check("rst_op_ready", op_if.op_ready, 0);
        check("rst_cnt_we", cnt_we, 0);
        check("rst_pc_we", pc_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_cnt_out", cnt_out, 0);
        RESET = 0; w_rst = 0;
        @(negedge CLK);

        run_instr(KIND_JR,   0,    0, 'h1234, 'h05, 0, 0, -1);
        run_instr(KIND_JR,   0,    0, 'h0002, 'hFC, 0, 0, -1);
        run_instr(KIND_JRCC, CC_Z, 1, 'h4000, 'h10, 0, 0, 'b01);
        run_instr(KIND_JRCC, CC_C, 0, 'h8000, 'h80, 0, 0, 'b10);
        run_instr(KIND_DJNZ, 0,    0, 'h0100, 'h20, 'h01, 0, -1);
        run_instr(KIND_DJNZ, 0,    0, 'h0100, 'hF0, 'h00, 0, -1);
        run_instr(KIND_JR,   0,    0, 'hFFF0, 'h7F, 0, 3, -1);
        run_instr(KIND_RSVD, 0,    0, 'h1111, 'h01, 0, 1, -1);
        repeat (60) begin
            run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                      $urandom_range(0, 65535), $urandom_range(0, 255),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 255),
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3), -1);
        end
        repeat (4) @(negedge CLK);
        check("q_pc_empty", q_pc_cyc.size(), 0);
        check("q_cnt_empty", q_cnt_cyc.size(), 0);
        check("q_done_empty", q_done.size(), 0);
        check("q_acc_empty", q_acc.size(), 0);

        // Wide build: reset lands while the target is being written.
        w_start = 1; w_kind = KIND_JR; w_pc_base = 24'h123456;
        w_op.op_valid = 1; w_op.op_data = 16'h8000;
        @(negedge CLK);
        w_start = 0;
        check("wide_fetch_ready", w_op.op_ready, 1);
        @(negedge CLK);
        check("wide_add_pc_we", w_pc_we, 1);
        check("wide_add_pc_out", w_pc_out, 24'h11B456);
        w_rst = 1;
        @(negedge CLK);
        w_rst = 0;
        check("wide_rst_busy", w_busy, 0);
        check("wide_rst_done", w_done, 0);
        check("wide_rst_pc_we", w_pc_we, 0);
        check("wide_rst_cnt_we", w_cnt_we, 0);
        check("wide_rst_op_ready", w_op.op_ready, 0);
        check("wide_rst_pc_out", w_pc_out, 0);
        check("wide_rst_cnt_out", w_cnt_out, 0);
        repeat (2) begin
            @(negedge CLK);
            check("wide_no_done", w_done, 0);
        end
        w_start = 1; w_pc_base = 24'hFFFFFF; w_op.op_data = 16'h0002; w_op.op_valid = 1;
        n = 0;
        do begin
            @(negedge CLK);
            w_start = 0;
            n++;
            if (w_pc_we) begin
                check("wide_fresh_we_cycle", n, 2);
                check("wide_fresh_pc_out", w_pc_out, 24'h000001);
            end
        end while (!w_done && n < 10);
        check("wide_fresh_done_lat", n, 3);
        check("wide_fresh_pc_hold", w_pc_out, 24'h000001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
